// File: rtl/sync_fifo_flags.sv
// Single-clock first-word-fall-through FIFO with occupancy count, threshold flags,
// sticky overflow/underflow error flags and a synchronous flush.
module sync_fifo_flags #(
  parameter int DEPTH     = 8,
  parameter int DATA_W    = 16,
  parameter int AFULL_TH  = 6,
  parameter int AEMPTY_TH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          push_data_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] AFULL_LVL  = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] AEMPTY_LVL = CNT_W'(AEMPTY_TH);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic [CNT_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic              overflow_r;
  logic              underflow_r;
  logic              empty_s;
  logic              full_s;
  logic              pop_ok_s;
  logic              push_ok_s;
  logic [DATA_W-1:0] head_s;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign full_s    = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                     (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign pop_ok_s  = pop_i & ~empty_s;
  assign push_ok_s = push_i & (~full_s | pop_ok_s);

  // Occupancy next-state from accepted push/pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + ONE;
      2'b01:   count_nxt_s = count_r - ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, count and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (clear_i) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + ONE;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + ONE;
      count_r     <= count_nxt_s;
      overflow_r  <= overflow_r  | (push_i & ~push_ok_s);
      underflow_r <= underflow_r | (pop_i & ~pop_ok_s);
    end
  end

  // Storage array; contents survive flush and reset, only the pointers move.
  always_ff @(posedge clk) begin
    if (push_ok_s && !clear_i && !reset) begin
      mem_r[wr_ptr_r[PTR_W-1:0]] <= push_data_i;
    end
  end

  // Head entry is masked to zero while empty so stale memory never leaks out.
  always_comb begin
    head_s = '0;
    if (empty_s) begin
      head_s = '0;
    end else begin
      head_s = mem_r[rd_ptr_r[PTR_W-1:0]];
    end
  end

  assign pop_data_o     = head_s;
  assign full_o         = full_s;
  assign empty_o        = empty_s;
  assign count_o        = count_r;
  assign almost_full_o  = (count_r >= AFULL_LVL);
  assign almost_empty_o = (count_r <= AEMPTY_LVL);
  assign overflow_o     = overflow_r;
  assign underflow_o    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed self-checking bench for sync_fifo_flags (DEPTH=8, DATA_W=16).
module tb_sync_fifo_flags;

  logic        clk;
  logic        reset;
  logic        clear_i;
  logic        push_i;
  logic [15:0] push_data_i;
  logic        pop_i;
  logic [15:0] pop_data_o;
  logic        full_o;
  logic        empty_o;
  logic        almost_full_o;
  logic        almost_empty_o;
  logic [3:0]  count_o;
  logic        overflow_o;
  logic        underflow_o;

  int tests_run;
  int tests_failed;

  sync_fifo_flags #(.DEPTH(8), .DATA_W(16), .AFULL_TH(6), .AEMPTY_TH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .clear_i        (clear_i),
    .push_i         (push_i),
    .push_data_i    (push_data_i),
    .pop_i          (pop_i),
    .pop_data_o     (pop_data_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic p, input logic [15:0] d, input logic q, input logic c);
    push_i      = p;
    push_data_i = d;
    pop_i       = q;
    clear_i     = c;
    @(posedge clk);
    #1;
    push_i      = 1'b0;
    push_data_i = 16'h0000;
    pop_i       = 1'b0;
    clear_i     = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    clear_i      = 1'b0;
    push_i       = 1'b0;
    push_data_i  = 16'h0000;
    pop_i        = 1'b0;
    reset        = 1'b1;
    #2;
    check_eq("rst_count",   32'(count_o),        32'd0);
    check_eq("rst_empty",   32'(empty_o),        32'd1);
    check_eq("rst_full",    32'(full_o),         32'd0);
    check_eq("rst_aempty",  32'(almost_empty_o), 32'd1);
    check_eq("rst_afull",   32'(almost_full_o),  32'd0);
    check_eq("rst_ovf",     32'(overflow_o),     32'd0);
    check_eq("rst_unf",     32'(underflow_o),    32'd0);
    check_eq("rst_data",    32'(pop_data_o),     32'd0);
    #10;
    reset = 1'b0;

    // 1. fill and drain
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0);
      check_eq("t1_count", 32'(count_o), 32'(i + 1));
      if (i == 0) check_eq("t1_first_head", 32'(pop_data_o), 32'h1000);
      if (i == 1) check_eq("t1_aempty_at2", 32'(almost_empty_o), 32'd1);
      if (i == 2) check_eq("t1_aempty_at3", 32'(almost_empty_o), 32'd0);
      if (i == 4) check_eq("t1_afull_at5",  32'(almost_full_o),  32'd0);
      if (i == 5) check_eq("t1_afull_at6",  32'(almost_full_o),  32'd1);
      if (i == 6) check_eq("t1_full_at7",   32'(full_o),         32'd0);
    end
    check_eq("t1_full",  32'(full_o),  32'd1);
    check_eq("t1_empty", 32'(empty_o), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check_eq("t1_head", 32'(pop_data_o), 32'h1000 + 32'(i));
      cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    end
    check_eq("t1_empty_end", 32'(empty_o),     32'd1);
    check_eq("t1_count_end", 32'(count_o),     32'd0);
    check_eq("t1_data_end",  32'(pop_data_o),  32'd0);
    check_eq("t1_ovf",       32'(overflow_o),  32'd0);
    check_eq("t1_unf",       32'(underflow_o), 32'd0);

    // 2. overflow
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0);
    cyc(1'b1, 16'hDEAD, 1'b0, 1'b0);
    check_eq("t2_ovf",   32'(overflow_o), 32'd1);
    check_eq("t2_count", 32'(count_o),    32'd8);
    for (int i = 0; i < 8; i++) begin
      check_eq("t2_head", 32'(pop_data_o), 32'h2000 + 32'(i));
      cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    end
    check_eq("t2_empty",    32'(empty_o),    32'd1);
    check_eq("t2_ovf_hold", 32'(overflow_o), 32'd1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1);
    check_eq("t2_ovf_clr",  32'(overflow_o), 32'd0);

    // 3. underflow, then push+pop on empty
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    check_eq("t3_unf",   32'(underflow_o), 32'd1);
    check_eq("t3_count", 32'(count_o),     32'd0);
    cyc(1'b1, 16'hA5A5, 1'b1, 1'b0);
    check_eq("t3_count1", 32'(count_o),    32'd1);
    check_eq("t3_head",   32'(pop_data_o), 32'hA5A5);
    check_eq("t3_empty",  32'(empty_o),    32'd0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1);
    check_eq("t3_clr_unf", 32'(underflow_o), 32'd0);

    // 4. simultaneous push+pop while full, across pointer wrap
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      check_eq("t4_head", 32'(pop_data_o), 32'(k));
      cyc(1'b1, 16'(k + 8), 1'b1, 1'b0);
      check_eq("t4_count", 32'(count_o),    32'd8);
      check_eq("t4_ovf",   32'(overflow_o), 32'd0);
      check_eq("t4_full",  32'(full_o),     32'd1);
    end
    for (int i = 0; i < 8; i++) begin
      check_eq("t4_drain", 32'(pop_data_o), 32'(20 + i));
      cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    end
    check_eq("t4_empty", 32'(empty_o),     32'd1);
    check_eq("t4_unf",   32'(underflow_o), 32'd0);

    // 5. flush with 5 entries, overflow set, push asserted
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'h5000 + 16'(i), 1'b0, 1'b0);
    cyc(1'b1, 16'h5555, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    check_eq("t5_count5", 32'(count_o),    32'd5);
    check_eq("t5_ovf",    32'(overflow_o), 32'd1);
    cyc(1'b1, 16'hBEEF, 1'b0, 1'b1);
    check_eq("t5_count", 32'(count_o),     32'd0);
    check_eq("t5_empty", 32'(empty_o),     32'd1);
    check_eq("t5_ovf0",  32'(overflow_o),  32'd0);
    check_eq("t5_unf0",  32'(underflow_o), 32'd0);
    check_eq("t5_data",  32'(pop_data_o),  32'd0);

    // 6. asynchronous reset between edges during traffic
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    check_eq("t6_unf_pre", 32'(underflow_o), 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h6000 + 16'(i), 1'b0, 1'b0);
    check_eq("t6_count_pre", 32'(count_o), 32'd3);
    push_i      = 1'b1;
    push_data_i = 16'h6666;
    pop_i       = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    check_eq("t6_count",  32'(count_o),        32'd0);
    check_eq("t6_empty",  32'(empty_o),        32'd1);
    check_eq("t6_aempty", 32'(almost_empty_o), 32'd1);
    check_eq("t6_unf",    32'(underflow_o),    32'd0);
    check_eq("t6_data",   32'(pop_data_o),     32'd0);
    push_i      = 1'b0;
    push_data_i = 16'h0000;
    pop_i       = 1'b0;
    #12;
    reset = 1'b0;
    #1;
    check_eq("t6_count_rel", 32'(count_o), 32'd0);
    cyc(1'b1, 16'h7777, 1'b0, 1'b0);
    check_eq("t6_restart_head",  32'(pop_data_o), 32'h7777);
    check_eq("t6_restart_count", 32'(count_o),    32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parameterised synchronous FIFO with occupancy count, programmable almost-full/almost-empty thresholds, guarded push/pop, sticky overflow/underflow error flags and a synchronous flush. It is the general-purpose buffering element between producer and consumer stages in a single clock domain. Read data is first-word-fall-through: the head entry is always visible on `pop_data_o`.

## Interface
- `DEPTH`, default 8: number of entries. Must be a power of two and at least 2.
- `DATA_W`, default 16: entry width in bits.
- `AFULL_TH`, default 6: `almost_full_o` asserts when count ≥ `AFULL_TH`. Range 1..`DEPTH`.
- `AEMPTY_TH`, default 2: `almost_empty_o` asserts when count ≤ `AEMPTY_TH`. Range 0..`DEPTH-1`.
- `clk`, input, 1: the single clock. All state updates on the rising edge.
- `reset`, input, 1: reset, asynchronous and active-high.
- `clear_i`, input, 1: synchronous flush.
- `push_i`, input, 1: push request.
- `push_data_i`, input, `DATA_W`: data to write.
- `pop_i`, input, 1: pop request.
- `pop_data_o`, output, `DATA_W`: head entry.
- `full_o`, output, 1: count == `DEPTH`.
- `empty_o`, output, 1: count == 0.
- `almost_full_o`, output, 1: almost-full threshold flag.
- `almost_empty_o`, output, 1: almost-empty threshold flag.
- `count_o`, output, `$clog2(DEPTH)+1`: current occupancy.
- `overflow_o`, output, 1: sticky; a push was rejected.
- `underflow_o`, output, 1: sticky; a pop was rejected.

## Operation
- **State.** Read and write pointers are each `$clog2(DEPTH)+1` bits; the MSB is the wrap bit. The state also holds a registered count, two sticky flags and the memory.
- **Pop acceptance.** `pop_ok = pop_i & ~empty_o`.
- **Push acceptance.** `push_ok = push_i & (~full_o | pop_ok)`. When full, a simultaneous push and pop are both accepted.
- **Empty with push and pop.** Only the push is accepted. There is no bypass path. `underflow_o` sets.
- **Write.** On `push_ok`, `mem[wr_ptr[PTR_W-1:0]] <= push_data_i` and `wr_ptr` increments. Pointers wrap modulo 2·`DEPTH`.
- **Read.** On `pop_ok`, `rd_ptr` increments.
- **Count.** The count updates by +1 (push only), −1 (pop only) or 0 (both or neither).
- **Head data.** `pop_data_o = mem[rd_ptr[PTR_W-1:0]]` when `empty_o`=0, and all-zeros when `empty_o`=1.
- **Error flags.** `overflow_o` sets on `push_i & ~push_ok`. `underflow_o` sets on `pop_i & ~pop_ok`. Both hold until `clear_i` or `reset`.
- **Flush.** `clear_i`=1 zeroes the pointers, the count and both sticky flags on the next edge. It overrides any push or pop in the same cycle. Memory contents are not cleared.
- **Flag derivation.** `full_o` and `empty_o` derive from pointer compare:
  - empty when the pointers are equal;
  - full when the wrap bits differ and the index bits are equal.
  - `full_o`/`empty_o` must always agree with `count_o`.
- **Thresholds.** The almost flags are compared against the registered count. Both flags may be high together when the thresholds overlap.

## Timing
- **Reset values.** `count_o`=0, `empty_o`=1, `full_o`=0, `almost_empty_o`=1, `almost_full_o`=0 (`AFULL_TH` ≥ 1), `overflow_o`=0, `underflow_o`=0, `pop_data_o`=0.
- **Reset mid-operation.** Reset asserted at any time discards all content immediately, without waiting for a clock edge.
- **Write-to-read latency.** Data pushed at edge N is visible on `pop_data_o` after edge N (one cycle) if the FIFO was empty.
- **Head advance.** A pop at edge N presents the next entry after edge N. The consumer samples `pop_data_o` in the same cycle it asserts `pop_i`.
- **Flag latency.** All flags and `count_o` reflect the state after the most recent edge. There is no combinational path from `push_i`/`pop_i` to any flag.
- **Combinational paths.** `pop_data_o` depends only on registered state and memory. The only input-to-acceptance combinational path is `pop_i` → `push_ok`.

## Test plan
1. **Fill and drain.** DEPTH=8, DATA_W=16. Push 8 words 0x1000..0x1007 on consecutive cycles, then pop 8.
   - `full_o`=1 and `count_o`=8 after the 8th push.
   - `almost_full_o` rises after the 6th push.
   - Pops return 0x1000..0x1007 in order; `empty_o`=1 afterwards.
   - No error flags set.
2. **Overflow.** Fill to 8, then push 0xDEAD.
   - `overflow_o`=1 and `count_o` stays 8.
   - The drained sequence contains no 0xDEAD.
3. **Underflow and empty push+pop.** From empty, pop once → `underflow_o`=1, `count_o`=0. Then push 0xA5A5 with pop in the same cycle → count=1 and head=0xA5A5.
4. **Full push+pop.** Fill with 0..7, then push 0x0008 and pop together.
   - Count stays 8 and `overflow_o`=0.
   - Full drain returns 1..8.
   - Run 20 such cycles to exercise pointer wrap.
5. **Flush.** With 5 entries, `overflow_o` set and push asserted, pulse `clear_i`. The next cycle shows `count_o`=0, `empty_o`=1 and both sticky flags 0.
6. **Asynchronous reset mid-stream.** Assert `reset` between edges during mixed traffic. All outputs take their reset values before the next edge, and the FIFO restarts correctly after release.
